canvas_fetch: RTL

CANVAS_FETCH -- requirements
Module: canvas_fetch

---
 rtl/canvas_fetch_pkg.sv | 33 +++
 rtl/canvas_ram.sv | 35 +++
 rtl/canvas_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/canvas_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : canvas_fetch_pkg                                                 |
// | Purpose : Shared colour codes, fetch FSM state type and a small cell-      |
// |           distance helper used by the canvas fetch pipeline.               |
// | Ports   : (package, none)                                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package canvas_fetch_pkg;

  // 3-bit palette codes consumed by the colour decode stage.
  localparam logic [2:0] COLOR_ERASE   = 3'd0;
  localparam logic [2:0] COLOR_RED     = 3'd1;
  localparam logic [2:0] COLOR_GREEN   = 3'd2;
  localparam logic [2:0] COLOR_BLUE    = 3'd3;
  localparam logic [2:0] COLOR_YELLOW  = 3'd4;
  localparam logic [2:0] COLOR_CYAN    = 3'd5;
  localparam logic [2:0] COLOR_MAGENTA = 3'd6;
  localparam logic [2:0] COLOR_BLACK   = 3'd7;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } fetch_state_t;

  // True when a and b are at most r apart. Signed int arithmetic keeps cells
  // at the canvas edge from wrapping around to the far side.
  function automatic logic cell_near(input int a, input int b, input int r);
    return ((a - b) <= r) && ((b - a) <= r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/canvas_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : canvas_ram                                                       |
// | Purpose : Simple dual-port colour store, one write port and one registered |
// |           read port (read-before-write on address collision).              |
// | Ports   : clk; we/waddr/wdata write port; raddr in, rdata out (1 cycle).   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module canvas_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset on the array: contents are initialised by the clear sweep.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Both updates are non-blocking, so a same-cycle read of the written
  // address returns the previous contents.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/canvas_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : canvas_fetch                                                     |
// | Purpose : Paint canvas storage with clear sweep, paint write channel and a |
// |           2-cycle display fetch pipeline with brush cursor overlay.        |
// | Ports   : clk, reset_n (async, active low)                                 |
// |           hcount/vcount/visible/hsync_in/vsync_in  raster timing in        |
// |           wr_valid/wr_ready/wr_x/wr_y/wr_color     paint write channel     |
// |           clear_req in, clear_done out (1-cycle pulse)                     |
// |           brush_x/brush_y                          cursor cell             |
// |           colorCode/brush/hsync/vsync/de           to colour decode        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module canvas_fetch
  import canvas_fetch_pkg::*;
#(
  parameter int CANVAS_W    = 160,
  parameter int CANVAS_H    = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int BRUSH_R     = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       visible,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       clear_req,
  output logic       clear_done,
  input  logic [7:0] brush_x,
  input  logic [6:0] brush_y,
  output logic [2:0] colorCode,
  output logic       brush,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);

  localparam int DEPTH  = CANVAS_W * CANVAS_H;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_sweep_addr;

  logic              w_wr_in_range;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [2:0]        w_ram_wdata;

  logic [9:0]        w_cell_x;
  logic [9:0]        w_cell_y;
  logic              w_rd_in_range;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [2:0]        w_rd_data;
  logic              w_brush_hit;

  logic              r_vis_d1;
  logic              r_hs_d1;
  logic              r_vs_d1;
  logic              r_brush_d1;

  // ---------------------------------------------------------------- write side
  assign wr_ready      = (r_state == ST_IDLE);
  assign w_wr_in_range = (int'(wr_x) < CANVAS_W) && (int'(wr_y) < CANVAS_H);
  assign w_wr_addr     = ADDR_W'(int'(wr_y) * CANVAS_W + int'(wr_x));

  // The sweep owns the write port while clearing; out-of-range paint writes
  // still handshake but never reach the array.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = w_wr_addr;
    w_ram_wdata = wr_color;
    if (r_state == ST_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_sweep_addr;
      w_ram_wdata = COLOR_ERASE;
    end else if (wr_valid && w_wr_in_range) begin
      w_ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_CLEAR;
      r_sweep_addr <= '0;
      clear_done   <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (r_state)
        // clear_req is not looked at here, so a request mid-sweep is dropped.
        ST_CLEAR: begin
          if (r_sweep_addr == LAST_ADDR) begin
            r_state      <= ST_IDLE;
            r_sweep_addr <= '0;
            clear_done   <= 1'b1;
          end else begin
            r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state      <= ST_CLEAR;
            r_sweep_addr <= '0;
          end
        end
        default: begin
          r_state      <= ST_CLEAR;
          r_sweep_addr <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------- display side
  assign w_cell_x      = hcount >> SCALE_SHIFT;
  assign w_cell_y      = vcount >> SCALE_SHIFT;
  assign w_rd_in_range = (int'(w_cell_x) < CANVAS_W) && (int'(w_cell_y) < CANVAS_H);
  // Off-canvas raster positions read address 0 to stay inside the array.
  assign w_rd_addr     = w_rd_in_range ?
                         ADDR_W'(int'(w_cell_y) * CANVAS_W + int'(w_cell_x)) : '0;
  assign w_brush_hit   = visible &&
                         cell_near(int'(w_cell_x), int'(brush_x), BRUSH_R) &&
                         cell_near(int'(w_cell_y), int'(brush_y), BRUSH_R);

  canvas_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (3)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

  // Stage 1 tracks the RAM read latency; stage 2 registers all outputs so the
  // colour and sync signals leave aligned, two cycles after the raster.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vis_d1   <= 1'b0;
      r_hs_d1    <= 1'b1;
      r_vs_d1    <= 1'b1;
      r_brush_d1 <= 1'b0;
      colorCode  <= COLOR_ERASE;
      brush      <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
    end else begin
      r_vis_d1   <= visible;
      r_hs_d1    <= hsync_in;
      r_vs_d1    <= vsync_in;
      r_brush_d1 <= w_brush_hit;
      colorCode  <= r_vis_d1 ? w_rd_data : COLOR_ERASE;
      brush      <= r_brush_d1;
      hsync      <= r_hs_d1;
      vsync      <= r_vs_d1;
      de         <= r_vis_d1;
    end
  end

endmodule
`default_nettype wire
